// File: rtl/atp_pkg.sv
// Shared ATP definitions: cash codes, FSM state encoding and code-to-rupee lookup.
// Used by both the note acceptor side and the change dispenser.
package atp_pkg;

    localparam int VAL_W     = 16;
    localparam int NUM_DENOM = 5;

    localparam logic [2:0] CASH_NONE = 3'b000;
    localparam logic [2:0] CASH_10   = 3'b001;
    localparam logic [2:0] CASH_50   = 3'b010;
    localparam logic [2:0] CASH_100  = 3'b011;
    localparam logic [2:0] CASH_200  = 3'b100;
    localparam logic [2:0] CASH_500  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE,
        ST_SHORT
    } state_t;

    function automatic logic [VAL_W-1:0] cash_value(input logic [2:0] code);
        case (code)
            CASH_10:  cash_value = VAL_W'(10);
            CASH_50:  cash_value = VAL_W'(50);
            CASH_100: cash_value = VAL_W'(100);
            CASH_200: cash_value = VAL_W'(200);
            CASH_500: cash_value = VAL_W'(500);
            default:  cash_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/atp_change_dispenser_if.sv
// Refund request, stock maintenance and note-ejector handshake of the change dispenser.
interface atp_change_dispenser_if #(
    parameter int AMT_W = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [AMT_W-1:0] refund_amount;
    logic             stock_load;
    logic [2:0]       stock_code;
    logic [CNT_W-1:0] stock_count;
    logic             note_ack;
    logic             note_valid;
    logic [2:0]       note_code;
    logic             busy;
    logic             done;
    logic             short_fall;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] dispensed_total;

    modport master (
        output start, refund_amount, stock_load, stock_code, stock_count, note_ack,
        input  note_valid, note_code, busy, done, short_fall, remaining, dispensed_total
    );

    modport slave (
        input  start, refund_amount, stock_load, stock_code, stock_count, note_ack,
        output note_valid, note_code, busy, done, short_fall, remaining, dispensed_total
    );
endinterface

// File: rtl/atp_denom_select.sv
// Greedy priority picker: largest denomination that fits the balance and is still in stock.
module atp_denom_select
    import atp_pkg::*;
#(
    parameter int AMT_W = 16
) (
    input  logic [AMT_W-1:0]     remaining,
    input  logic [NUM_DENOM-1:0] stock_nz,
    output logic                 found,
    output logic [2:0]           code
);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        code  = CASH_NONE;
        // Walk from 500 down to 10; the first hit wins.
        for (int i = NUM_DENOM; i >= 1; i--) begin
            if (!found && stock_nz[i-1] && (AMT_W'(cash_value(3'(i))) <= remaining)) begin
                found = 1'b1;
                code  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/atp_change_dispenser.sv
// Change dispenser: pays a refund as notes, one per ejector handshake, from a stocked inventory.
// Flags a shortfall when the balance cannot be paid exactly.
module atp_change_dispenser
    import atp_pkg::*;
#(
    parameter int AMT_W    = 16,
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    atp_change_dispenser_if.slave  bus
);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] total_q;
    logic [2:0]       code_q;
    logic [CNT_W-1:0] stock [NUM_DENOM];

    logic [NUM_DENOM-1:0] stock_nz;
    logic                 sel_found;
    logic [2:0]           sel_code;
    logic                 take_note;
    logic [AMT_W-1:0]     note_val;

    always_comb begin
        stock_nz = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            stock_nz[i] = (stock[i] != '0);
        end
    end

    atp_denom_select #(.AMT_W(AMT_W)) u_select (
        .remaining (remaining_q),
        .stock_nz  (stock_nz),
        .found     (sel_found),
        .code      (sel_code)
    );

    assign note_val = AMT_W'(cash_value(code_q));

    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_note = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                // Zero balance must be tested first: the picker finds nothing for it.
                if (remaining_q == '0)  state_nxt = ST_DONE;
                else if (sel_found)     state_nxt = ST_ISSUE;
                else                    state_nxt = ST_SHORT;
            end
            ST_ISSUE: begin
                if (bus.note_ack) begin
                    take_note = 1'b1;
                    state_nxt = ST_SELECT;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_SHORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
            total_q     <= '0;
            code_q      <= CASH_NONE;
            // NOTE: the stock array is a true reset target; its reset value is the loaded inventory.
            for (int i = 0; i < NUM_DENOM; i++) begin
                stock[i] <= CNT_W'(INIT_CNT);
            end
        end else begin
            if (state == ST_IDLE && bus.start) begin
                remaining_q <= bus.refund_amount;
                total_q     <= '0;
            end
            if (state == ST_SELECT && remaining_q != '0 && sel_found) begin
                code_q <= sel_code;
            end
            if (take_note) begin
                remaining_q <= remaining_q - note_val;
                total_q     <= total_q + note_val;
            end
            // Codes 000/110/111 match no slot, so loads with them fall through untouched.
            for (int i = 0; i < NUM_DENOM; i++) begin
                if (state == ST_IDLE && bus.stock_load && bus.stock_code == 3'(i + 1)) begin
                    stock[i] <= bus.stock_count;
                end else if (take_note && code_q == 3'(i + 1)) begin
                    stock[i] <= stock[i] - CNT_W'(1);
                end
            end
        end
    end

    assign bus.note_valid      = (state == ST_ISSUE);
    assign bus.note_code       = code_q;
    assign bus.busy            = (state != ST_IDLE);
    assign bus.done            = (state == ST_DONE);
    assign bus.short_fall      = (state == ST_SHORT);
    assign bus.remaining       = remaining_q;
    assign bus.dispensed_total = total_q;

endmodule

// File: tb/tb_atp_change_dispenser.sv
// Scoreboard bench for the change dispenser: directed refunds, expected events queued, monitor compares.
module tb_atp_change_dispenser;
    import atp_pkg::*;

    localparam int AMT_W    = 16;
    localparam int CNT_W    = 8;
    localparam int INIT_CNT = 20;
    localparam int BUDGET   = 300;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    atp_change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus();

    atp_change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_NOTE, EV_DONE, EV_SHORT} ev_kind_t;
    typedef struct {
        ev_kind_t         kind;
        logic [2:0]       code;
        logic [AMT_W-1:0] rem;
        logic [AMT_W-1:0] tot;
    } ev_t;

    ev_t sb[$];
    int  checks    = 0;
    int  failures  = 0;
    int  ack_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_note(input logic [2:0] code);
        ev_t e;
        e.kind = EV_NOTE; e.code = code; e.rem = '0; e.tot = '0;
        sb.push_back(e);
    endtask

    task automatic push_end(input ev_kind_t kind, input int rem, input int tot);
        ev_t e;
        e.kind = kind; e.code = CASH_NONE; e.rem = AMT_W'(rem); e.tot = AMT_W'(tot);
        sb.push_back(e);
    endtask

    task automatic check_stock(input int s10, input int s50, input int s100, input int s200, input int s500);
        check("stock_10",  32'(dut.stock[0]), 32'(s10));
        check("stock_50",  32'(dut.stock[1]), 32'(s50));
        check("stock_100", 32'(dut.stock[2]), 32'(s100));
        check("stock_200", 32'(dut.stock[3]), 32'(s200));
        check("stock_500", 32'(dut.stock[4]), 32'(s500));
    endtask

    // Monitor: a rising note_valid or an end pulse consumes one expected event.
    initial begin
        logic       prev_valid;
        logic [2:0] held;
        ev_t        e;
        ev_kind_t   kind;
        prev_valid = 1'b0;
        held       = CASH_NONE;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                continue;
            end
            if (bus.note_valid && !prev_valid) begin
                held = bus.note_code;
                if (sb.size() == 0) begin
                    check("unexpected_note", 32'(bus.note_code), 32'(CASH_NONE));
                end else begin
                    e = sb.pop_front();
                    check("event_kind_note", 32'(EV_NOTE), 32'(e.kind));
                    check("note_code", 32'(bus.note_code), 32'(e.code));
                end
            end else if (bus.note_valid) begin
                check("note_code_stable", 32'(bus.note_code), 32'(held));
            end
            if (bus.done || bus.short_fall) begin
                kind = bus.done ? EV_DONE : EV_SHORT;
                if (sb.size() == 0) begin
                    check("unexpected_end", 32'(kind), 32'(EV_NOTE));
                end else begin
                    e = sb.pop_front();
                    check("event_kind_end", 32'(kind), 32'(e.kind));
                    check("end_remaining", 32'(bus.remaining), 32'(e.rem));
                    check("end_dispensed", 32'(bus.dispensed_total), 32'(e.tot));
                end
            end
            prev_valid = bus.note_valid;
        end
    end

    // Ejector model: acks a presented note after ack_delay idle cycles.
    initial begin
        int waited;
        waited       = 0;
        bus.note_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.note_valid && !reset) begin
                if (waited >= ack_delay) begin
                    bus.note_ack = 1'b1;
                end else begin
                    bus.note_ack = 1'b0;
                    waited++;
                end
            end else begin
                bus.note_ack = 1'b0;
                waited       = 0;
            end
        end
    end

    task automatic load_stock(input logic [2:0] code, input int cnt);
        @(negedge clk);
        bus.stock_load  = 1'b1;
        bus.stock_code  = code;
        bus.stock_count = CNT_W'(cnt);
        @(negedge clk);
        bus.stock_load  = 1'b0;
    endtask

    task automatic run_refund(input int amt, input bit inject, input bit load,
                              input logic [2:0] lcode, input int lcnt);
        int cyc;
        int first;
        bit injected;
        cyc      = 0;
        first    = -1;
        injected = 1'b0;
        @(negedge clk);
        bus.refund_amount = AMT_W'(amt);
        bus.start         = 1'b1;
        bus.stock_load    = load;
        bus.stock_code    = lcode;
        bus.stock_count   = CNT_W'(lcnt);
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.start      = 1'b0;
            bus.stock_load = 1'b0;
            if (first < 0 && (bus.note_valid || bus.done || bus.short_fall)) first = cyc;
            // Mid-ISSUE start and stock_load must both be ignored.
            if (inject && !injected && bus.note_valid) begin
                bus.start         = 1'b1;
                bus.refund_amount = AMT_W'(500);
                bus.stock_load    = 1'b1;
                bus.stock_code    = CASH_50;
                bus.stock_count   = '0;
                injected          = 1'b1;
            end
            if (!bus.busy) break;
        end
        check("first_event_latency", 32'(first), 32'd2);
        check("refund_finished", 32'(cyc < BUDGET), 32'd1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.start         = 1'b0;
        bus.refund_amount = '0;
        bus.stock_load    = 1'b0;
        bus.stock_code    = CASH_NONE;
        bus.stock_count   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_note_valid", 32'(bus.note_valid), 32'd0);
        check("rst_note_code",  32'(bus.note_code),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_short_fall", 32'(bus.short_fall), 32'd0);
        check("rst_remaining",  32'(bus.remaining),  32'd0);
        check("rst_dispensed",  32'(bus.dispensed_total), 32'd0);
        check_stock(20, 20, 20, 20, 20);
        reset = 1'b0;

        // 350 = 200 + 100 + 50
        push_note(CASH_200); push_note(CASH_100); push_note(CASH_50);
        push_end(EV_DONE, 0, 350);
        run_refund(350, 1'b0, 1'b0, CASH_NONE, 0);
        check_stock(20, 19, 19, 19, 20);

        // Zero refund: done only, no note
        push_end(EV_DONE, 0, 0);
        run_refund(0, 1'b0, 1'b0, CASH_NONE, 0);
        check("zero_remaining", 32'(bus.remaining), 32'd0);

        // 35: three tens, residue 5 held
        push_note(CASH_10); push_note(CASH_10); push_note(CASH_10);
        push_end(EV_SHORT, 5, 30);
        run_refund(35, 1'b0, 1'b0, CASH_NONE, 0);
        check("short_remaining_held", 32'(bus.remaining), 32'd5);
        check_stock(17, 19, 19, 19, 20);

        // 200s emptied (invalid codes ignored), 400 paid as four 100s
        apply_reset();
        load_stock(CASH_200, 0);
        load_stock(3'b111, 0);
        load_stock(3'b000, 0);
        check_stock(20, 20, 20, 0, 20);
        for (int i = 0; i < 4; i++) push_note(CASH_100);
        push_end(EV_DONE, 0, 400);
        run_refund(400, 1'b0, 1'b0, CASH_NONE, 0);
        check_stock(20, 20, 16, 0, 20);

        // start together with stock_load of one 500: 500 + 5 x 100
        push_note(CASH_500);
        for (int i = 0; i < 5; i++) push_note(CASH_100);
        push_end(EV_DONE, 0, 1000);
        run_refund(1000, 1'b0, 1'b1, CASH_500, 1);
        check_stock(20, 20, 11, 0, 0);

        // Slow ejector plus ignored start/stock_load during ISSUE
        ack_delay = 3;
        push_note(CASH_50); push_note(CASH_10);
        push_end(EV_DONE, 0, 60);
        run_refund(60, 1'b1, 1'b0, CASH_NONE, 0);
        check_stock(19, 19, 11, 0, 0);

        // Reset while a note is presented
        ack_delay = 100000;
        push_note(CASH_10);
        @(negedge clk);
        bus.refund_amount = AMT_W'(10);
        bus.start         = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.note_valid) break;
        end
        check("issue_reached", 32'(bus.note_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_note_valid", 32'(bus.note_valid), 32'd0);
        check("abort_busy",       32'(bus.busy),       32'd0);
        check("abort_remaining",  32'(bus.remaining),  32'd0);
        check_stock(20, 20, 20, 20, 20);
        reset = 1'b0;
        sb.delete();
        ack_delay = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "timeout");
    end

endmodule
